// File: rtl/uart_line_engine.sv
// Line engine between the UART RX FIFO and the TX FIFO. It echoes each byte as it
// arrives, or buffers a line up to a terminator and replays it as-is, uppercased or reversed.
module uart_line_engine #(
    parameter int         LINE_DEPTH = 64,
    parameter logic [7:0] TERMINATOR = 8'h0D,
    parameter bit         APPEND_LF  = 1'b1,
    parameter int         LCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              rx_fifo_empty,
    input  logic [7:0]        rx_fifo_data_out,
    output logic              rx_fifo_read_en,
    input  logic              uart_tx_fifo_ready,
    output logic              start_uart_tx,
    output logic [7:0]        uart_tx_data,
    input  logic              clear_overflow,
    output logic              overflow_flag,
    output logic [LCNT_W-1:0] line_count,
    output logic              busy
);

    localparam int              AW       = $clog2(LINE_DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C  = CW'(LINE_DEPTH);
    localparam logic [CW-1:0]   ONE_C    = CW'(1);
    localparam logic [LCNT_W-1:0] LCNT_ONE = LCNT_W'(1);
    localparam logic [1:0]      MODE_ECHO  = 2'b00;
    localparam logic [1:0]      MODE_UPPER = 2'b10;
    localparam logic [1:0]      MODE_REV   = 2'b11;
    localparam logic [7:0]      LF_BYTE    = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        DECIDE,
        TX_BYTE,
        GAP,
        FLUSH,
        SEND_TERM,
        SEND_LF
    } state_t;

    state_t              state_q, state_d;
    state_t              after_q, after_d;
    logic [7:0]          hold_q, hold_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [1:0]          mode_q, mode_d;
    logic                ovf_q, ovf_d;
    logic [LCNT_W-1:0]   lcnt_q, lcnt_d;

    logic [7:0]          line_buf [LINE_DEPTH];
    logic                buf_we;
    logic [AW-1:0]       rd_addr;
    logic [7:0]          rd_byte;
    logic [7:0]          flush_byte;
    logic                pop_req;
    logic                ovf_set;

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if (b >= 8'h61 && b <= 8'h7A) begin
            return b - 8'h20;
        end
        return b;
    endfunction

    // Reversed lines are read from the top of the filled region downwards.
    always_comb begin
        if (mode_q == MODE_REV) begin
            rd_addr = AW'(count_q - ONE_C - idx_q);
        end else begin
            rd_addr = AW'(idx_q);
        end
        rd_byte    = line_buf[rd_addr];
        flush_byte = (mode_q == MODE_UPPER) ? to_upper(rd_byte) : rd_byte;
    end

    always_comb begin
        state_d       = state_q;
        after_d       = after_q;
        hold_d        = hold_q;
        count_d       = count_q;
        idx_d         = idx_q;
        mode_d        = mode_q;
        lcnt_d        = lcnt_q;
        ovf_set       = 1'b0;
        buf_we        = 1'b0;
        pop_req       = 1'b0;
        start_uart_tx = 1'b0;
        uart_tx_data  = 8'h00;

        case (state_q)
            IDLE: begin
                if (count_q == '0) begin
                    mode_d = mode;
                end
                if (!rx_fifo_empty) begin
                    pop_req = 1'b1;
                    hold_d  = rx_fifo_data_out;
                    state_d = POP;
                end
            end
            POP: begin
                state_d = DECIDE;
            end
            DECIDE: begin
                if (mode_q == MODE_ECHO) begin
                    state_d = TX_BYTE;
                end else if (hold_q == TERMINATOR) begin
                    idx_d   = '0;
                    state_d = (count_q == '0) ? SEND_TERM : FLUSH;
                end else if (count_q < DEPTH_C) begin
                    buf_we  = 1'b1;
                    count_d = count_q + ONE_C;
                    state_d = IDLE;
                end else begin
                    ovf_set = 1'b1;
                    state_d = IDLE;
                end
            end
            TX_BYTE: begin
                uart_tx_data = hold_q;
                if (uart_tx_fifo_ready) begin
                    start_uart_tx = 1'b1;
                    after_d       = IDLE;
                    state_d       = GAP;
                    if (hold_q == TERMINATOR) begin
                        lcnt_d = lcnt_q + LCNT_ONE;
                    end
                end
            end
            GAP: begin
                state_d = after_q;
            end
            FLUSH: begin
                uart_tx_data = flush_byte;
                if (uart_tx_fifo_ready) begin
                    start_uart_tx = 1'b1;
                    idx_d         = idx_q + ONE_C;
                    after_d       = ((idx_q + ONE_C) == count_q) ? SEND_TERM : FLUSH;
                    state_d       = GAP;
                end
            end
            SEND_TERM: begin
                uart_tx_data = TERMINATOR;
                if (uart_tx_fifo_ready) begin
                    start_uart_tx = 1'b1;
                    state_d       = GAP;
                    if (APPEND_LF) begin
                        after_d = SEND_LF;
                    end else begin
                        after_d = IDLE;
                        count_d = '0;
                        lcnt_d  = lcnt_q + LCNT_ONE;
                    end
                end
            end
            SEND_LF: begin
                uart_tx_data = LF_BYTE;
                if (uart_tx_fifo_ready) begin
                    start_uart_tx = 1'b1;
                    after_d       = IDLE;
                    count_d       = '0;
                    lcnt_d        = lcnt_q + LCNT_ONE;
                    state_d       = GAP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A drop in the same cycle as a clear request must stay visible.
        ovf_d = ovf_q;
        if (clear_overflow) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            after_q <= IDLE;
            hold_q  <= 8'h00;
            count_q <= '0;
            idx_q   <= '0;
            mode_q  <= 2'b00;
            ovf_q   <= 1'b0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            after_q <= after_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // Line storage carries no reset; the fill count decides what is valid.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf[AW'(count_q)] <= hold_q;
        end
    end

    assign rx_fifo_read_en = pop_req & rst_n;
    assign overflow_flag   = ovf_q;
    assign line_count      = lcnt_q;
    assign busy            = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_line_engine.sv
// Self-checking bench for uart_line_engine: directed scenarios plus randomized lines
// compared against a line-level reference model of the echo/transform rules.
module tb_uart_line_engine;

    localparam int         DEPTH = 4;
    localparam logic [7:0] TERM  = 8'h0D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        rx_fifo_empty;
    logic [7:0]  rx_fifo_data_out;
    logic        rx_fifo_read_en;
    logic        uart_tx_fifo_ready;
    logic        start_uart_tx;
    logic [7:0]  uart_tx_data;
    logic        clear_overflow;
    logic        overflow_flag;
    logic [15:0] line_count;
    logic        busy;

    uart_line_engine #(
        .LINE_DEPTH(DEPTH),
        .TERMINATOR(TERM),
        .APPEND_LF (1'b1),
        .LCNT_W    (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mode              (mode),
        .rx_fifo_empty     (rx_fifo_empty),
        .rx_fifo_data_out  (rx_fifo_data_out),
        .rx_fifo_read_en   (rx_fifo_read_en),
        .uart_tx_fifo_ready(uart_tx_fifo_ready),
        .start_uart_tx     (start_uart_tx),
        .uart_tx_data      (uart_tx_data),
        .clear_overflow    (clear_overflow),
        .overflow_flag     (overflow_flag),
        .line_count        (line_count),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // First-word-fall-through RX FIFO model; the read pointer advances on a pop.
    logic [7:0] rxMem [0:4095];
    int rxWr = 0;
    int rxRd = 0;
    assign rx_fifo_empty    = (rxWr == rxRd);
    assign rx_fifo_data_out = rxMem[rxRd[11:0]];
    always @(posedge clk) if (rx_fifo_read_en) rxRd <= rxRd + 1;

    // TX-side monitor: collects written bytes and counts handshake violations.
    logic [7:0] txq[$];
    int startTotal = 0, popTotal = 0;
    int spacingViol = 0, notReadyViol = 0, popViol = 0;
    int lastStart = -100, lastPop = -100;
    always @(negedge clk) begin
        if (start_uart_tx) begin
            txq.push_back(uart_tx_data);
            startTotal++;
            if (!uart_tx_fifo_ready) notReadyViol++;
            if (cyc - lastStart < 2) spacingViol++;
            lastStart = cyc;
        end
        if (rx_fifo_read_en) begin
            popTotal++;
            if (cyc - lastPop < 3) popViol++;
            lastPop = cyc;
        end
    end

    // TX ready driver: steady, stalled or random backpressure.
    bit stallReady = 1'b0;
    bit randReady  = 1'b0;
    initial begin
        uart_tx_fifo_ready = 1'b1;
        forever begin
            @(posedge clk);
            #3;
            if (stallReady)     uart_tx_fifo_ready = 1'b0;
            else if (randReady) uart_tx_fifo_ready = ($urandom_range(0, 3) != 0);
            else                uart_tx_fifo_ready = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  lineQ[$];
    logic [7:0]  expQ[$];
    int          txBase = 0;
    logic [15:0] expLcnt = 16'd0;
    logic        expOvf = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushByte(input logic [7:0] b);
        rxMem[rxWr[11:0]] = b;
        rxWr++;
    endtask

    task automatic setLine(input string s);
        lineQ.delete();
        for (int i = 0; i < s.len(); i++) lineQ.push_back(s[i]);
    endtask

    task automatic applyStimulus(input bit withTerm);
        tick();
        foreach (lineQ[i]) pushByte(lineQ[i]);
        if (withTerm) pushByte(TERM);
    endtask

    // Reference: echo verbatim, or keep the first DEPTH bytes, transform, add CR LF.
    task automatic modelLine(input logic [1:0] m, input bit withTerm);
        int         kept;
        logic [7:0] b;
        if (m == 2'b00) begin
            foreach (lineQ[i]) expQ.push_back(lineQ[i]);
            if (withTerm) begin
                expQ.push_back(TERM);
                expLcnt++;
            end
        end else begin
            kept = (lineQ.size() > DEPTH) ? DEPTH : lineQ.size();
            if (lineQ.size() > DEPTH) expOvf = 1'b1;
            for (int i = 0; i < kept; i++) begin
                b = (m == 2'b11) ? lineQ[kept - 1 - i] : lineQ[i];
                if (m == 2'b10 && b >= 8'h61 && b <= 8'h7A) b = b - 8'd32;
                expQ.push_back(b);
            end
            expQ.push_back(TERM);
            expQ.push_back(8'h0A);
            expLcnt++;
        end
    endtask

    task automatic startTest();
        txBase = txq.size();
        expQ.delete();
    endtask

    task automatic compareTx(input string tag);
        int got;
        got = txq.size() - txBase;
        checkOutput({tag, "_len"}, got, expQ.size());
        for (int i = 0; i < expQ.size() && i < got; i++)
            checkOutput(tag, txq[txBase + i], expQ[i]);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        @(negedge clk);
        while (n < 600 && !(rx_fifo_empty && !busy)) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_idle"}, {31'd0, rx_fifo_empty && !busy}, 32'd1);
    endtask

    task automatic waitTx(input int n, input string tag);
        int k = 0;
        while (k < 400 && (txq.size() < txBase + n)) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, "_txwait"}, {31'd0, txq.size() >= txBase + n}, 32'd1);
    endtask

    task automatic pulseClear();
        tick();
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput(tag, {7'd0, start_uart_tx, rx_fifo_read_en, uart_tx_data,
                          busy, overflow_flag, line_count}, 32'd0);
    endtask

    initial begin
        int firstRd, firstSt, s0, p0, n;
        logic [1:0] m;
        int len;

        rst_n = 1'b0;
        mode = 2'b00;
        clear_overflow = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset_state");
        tick();
        rst_n = 1'b1;

        // Mode 00 echo of "Hi", with first-pulse latency measured from the pop.
        startTest();
        setLine("Hi");
        modelLine(2'b00, 1'b0);
        applyStimulus(1'b0);
        firstRd = -1;
        firstSt = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_fifo_read_en && firstRd < 0) firstRd = cyc;
            if (start_uart_tx && firstSt < 0) firstSt = cyc;
        end
        checkOutput("echo_latency", firstSt - firstRd, 32'd3);
        waitIdle("echo");
        compareTx("echo_tx");
        checkOutput("echo_lcnt", line_count, expLcnt);

        // Buffered modes on short lines.
        tick();
        mode = 2'b01;
        startTest();
        setLine("ab");
        modelLine(2'b01, 1'b1);
        applyStimulus(1'b1);
        waitIdle("line01");
        compareTx("line01_tx");
        checkOutput("line01_lcnt", line_count, expLcnt);
        checkOutput("line01_busy", {31'd0, busy}, 32'd0);

        tick();
        mode = 2'b10;
        startTest();
        setLine("aZ9z");
        modelLine(2'b10, 1'b1);
        applyStimulus(1'b1);
        waitIdle("upper");
        compareTx("upper_tx");

        tick();
        mode = 2'b11;
        startTest();
        setLine("abc");
        modelLine(2'b11, 1'b1);
        applyStimulus(1'b1);
        waitIdle("rev");
        compareTx("rev_tx");
        checkOutput("rev_lcnt", line_count, expLcnt);

        // Overflow: buffer of 4, line "abcdef".
        tick();
        mode = 2'b01;
        startTest();
        setLine("abcdef");
        modelLine(2'b01, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) pushByte(lineQ[i]);
        repeat (20) @(negedge clk);
        checkOutput("ovf_before", {31'd0, overflow_flag}, 32'd0);
        tick();
        pushByte(lineQ[4]);
        repeat (10) @(negedge clk);
        checkOutput("ovf_after_e", {31'd0, overflow_flag}, 32'd1);
        tick();
        pushByte(lineQ[5]);
        pushByte(TERM);
        waitIdle("ovf");
        compareTx("ovf_tx");
        checkOutput("ovf_sticky", {31'd0, overflow_flag}, {31'd0, expOvf});
        checkOutput("ovf_lcnt", line_count, expLcnt);
        pulseClear();
        @(negedge clk);
        checkOutput("ovf_cleared", {31'd0, overflow_flag}, 32'd0);

        // Clear asserted in exactly the cycle the dropped byte is decided.
        startTest();
        setLine("abcde");
        modelLine(2'b01, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) pushByte(lineQ[i]);
        repeat (20) @(negedge clk);
        tick();
        pushByte(lineQ[4]);
        n = 0;
        @(negedge clk);
        while (n < 20 && !rx_fifo_read_en) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        tick();
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        @(negedge clk);
        checkOutput("ovf_set_wins", {31'd0, overflow_flag}, 32'd1);
        tick();
        pushByte(TERM);
        waitIdle("ovf2");
        compareTx("ovf2_tx");
        pulseClear();

        // 50-cycle TX stall in the middle of a flush with the next line queued.
        startTest();
        setLine("abcd");
        modelLine(2'b01, 1'b1);
        applyStimulus(1'b1);
        setLine("xy");
        modelLine(2'b01, 1'b1);
        foreach (lineQ[i]) pushByte(lineQ[i]);
        pushByte(TERM);
        waitTx(2, "stall");
        tick();
        stallReady = 1'b1;
        s0 = startTotal;
        p0 = popTotal;
        repeat (50) tick();
        checkOutput("stall_starts", startTotal - s0, 32'd0);
        checkOutput("stall_pops", popTotal - p0, 32'd0);
        stallReady = 1'b0;
        waitIdle("stall");
        compareTx("stall_tx");
        checkOutput("stall_lcnt", line_count, expLcnt);

        // Reset in the middle of a flush, with RX data pending during reset.
        startTest();
        setLine("abcd");
        applyStimulus(1'b1);
        waitTx(2, "rst");
        tick();
        rst_n = 1'b0;
        pushByte(8'h7A);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkResetOutputs("reset_mid_flush");
        end
        rxWr = rxRd;
        tick();
        rst_n = 1'b1;
        expLcnt = 16'd0;
        expOvf  = 1'b0;

        startTest();
        setLine("x");
        modelLine(2'b01, 1'b1);
        applyStimulus(1'b0);
        repeat (10) @(negedge clk);
        tick();
        mode = 2'b10;
        pushByte(TERM);
        waitIdle("post_rst");
        compareTx("post_rst_tx");
        checkOutput("post_rst_lcnt", line_count, expLcnt);

        // Randomized lines, modes and backpressure against the reference model.
        randReady = 1'b1;
        for (int l = 0; l < 40; l++) begin
            m = 2'($urandom_range(0, 3));
            len = $urandom_range(0, 6);
            pulseClear();
            expOvf = 1'b0;
            tick();
            mode = m;
            lineQ.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0)
                    lineQ.push_back(($urandom_range(0, 1) == 0) ? 8'h60 : 8'h7B);
                else
                    lineQ.push_back(8'($urandom_range(8'h20, 8'h7E)));
            end
            startTest();
            modelLine(m, 1'b1);
            applyStimulus(1'b1);
            waitIdle("rand");
            compareTx("rand_tx");
            checkOutput("rand_lcnt", line_count, expLcnt);
            checkOutput("rand_ovf", {31'd0, overflow_flag}, {31'd0, expOvf});
        end
        randReady = 1'b0;

        checkOutput("pulse_spacing", spacingViol, 32'd0);
        checkOutput("start_without_ready", notReadyViol, 32'd0);
        checkOutput("pop_spacing", popViol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
